sram_req_arbiter: RTL and testbench
===================================

# sram_req_arbiter

Two-to-one arbiter placed between the pipeline's SRAM-like masters (instruction fetch port and the execute-stage data port) and the single SRAM-like port of the AXI bridge. It grants one requester per address handshake and holds the grant until `addr_ok`. It records the owner of every accepted transaction in an in-order return FIFO, and routes `data_ok`/`rdata` back to that owner.

## Interface
- `MAX_OUTSTANDING`, 4: depth of the return-order FIFO (power of two, 2..16); max accepted-but-unreturned transactions.
- `clk` input 1: clock, rising edge.
- `resetn` input 1: asynchronous active-low reset.
- `inst_sram_req`, `inst_sram_wr` input 1 each; `inst_sram_size` input 2; `inst_sram_wstrb` input 4; `inst_sram_addr`, `inst_sram_wdata` input 32 each: fetch request.
- `inst_sram_addr_ok`, `inst_sram_data_ok` output 1 each; `inst_sram_rdata` output 32: fetch response.
- `data_sram_req`, `data_sram_wr` input 1 each; `data_sram_size` input 2; `data_sram_wstrb` input 4; `data_sram_addr`, `data_sram_wdata` input 32 each: execute-stage request.
- `data_sram_addr_ok`, `data_sram_data_ok` output 1 each; `data_sram_rdata` output 32: execute-stage response.
- `mem_req`, `mem_wr` output 1 each; `mem_size` output 2; `mem_wstrb` output 4; `mem_addr`, `mem_wdata` output 32 each: shared request toward the bridge.
- `mem_addr_ok`, `mem_data_ok` input 1 each; `mem_rdata` input 32: shared response. The bridge returns responses in acceptance order.

## Operation
- FSM `state`: IDLE, LOCK_I, LOCK_D.
  - IDLE: choose a winner among requesters whose `req`=1, using the policy in Configuration. Drive the winner's fields onto `mem_*` in the same cycle.
  - If the winner is granted, `mem_req`=1, and `mem_addr_ok`=0, go to LOCK_I or LOCK_D.
  - LOCK_x: only requester x is muxed to `mem_*`, even if the other requester raises `req`.
  - Leave LOCK_x for IDLE on `mem_addr_ok`=1, or when x drops `req`. The execute stage withdraws on flush, ALE, or `ms_allowin`=0. A withdrawal is legal and enqueues nothing.
- `mem_req` = selected `req` & ~`fifo_full`. `<x>_sram_addr_ok` = `mem_addr_ok` & `mem_req` & (owner==x). The non-owner's `addr_ok` is 0.
- Accept event (`mem_req` & `mem_addr_ok`): push owner id (0=inst, 1=data) into the return FIFO.
  - Writes (`mem_wr`=1) are also pushed; the bridge raises `data_ok` for writes too.
- Return event (`mem_data_ok`): pop the FIFO head.
  - `<head>_sram_data_ok`=1 for that cycle; the other requester's `data_ok` stays 0.
  - `inst_sram_rdata` and `data_sram_rdata` both carry `mem_rdata` unconditionally.
- Occupancy counter: width clog2(MAX_OUTSTANDING)+1.
  - Push only: +1. Pop only: −1. Push and pop in the same cycle: unchanged, and the head pop precedes the new tail write.
  - Pointers wrap modulo MAX_OUTSTANDING.
- Full (count==MAX_OUTSTANDING): `mem_req` forced to 0 and FSM state held. A `data_ok` in that cycle frees a slot for the next cycle, not the same cycle.
- Empty with `mem_data_ok`=1: protocol error. Both `data_ok` outputs stay 0, the counter does not underflow, and sticky internal flag `ret_err` is set for the bench.
- No flush input: responses for flushed transactions are still delivered. Discarding them is the requester's job.

## Timing
- Request path is combinational: `req` to `mem_req` and `mem_addr_ok` to `addr_ok` in 0 cycles. Response routing is also 0 cycles.
- The FIFO push is visible to the routing logic from the next cycle. Minimum accept-to-`data_ok` spacing is 1 cycle.
- Reset (async, `resetn`=0): state=IDLE, FIFO empty, pointers 0, `ret_err`=0, round-robin last-winner = data, so inst is favoured first.
- During reset all outputs are 0: `mem_req`, every `addr_ok` and `data_ok`, and the `mem_*` fields. Deassertion takes effect synchronously at the next edge.
- Reset mid-transaction drops all outstanding ownership. The bridge is reset by the same `resetn`.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin. On a simultaneous request in IDLE, the requester not granted last wins. Last-winner updates on each accept event only.
- `SRAM_ARB_RR_EN` undefined: fixed priority, data over inst. The last-winner register is not built.

## Test plan
- Lone fetch: `inst_sram_req`=1, addr 0x1C000000, bridge `addr_ok` in cycle 0 and `data_ok` in cycle 2 with rdata 0x02800C0C → `inst_sram_addr_ok` in cycle 0, `inst_sram_data_ok`=1 in cycle 2, `data_sram_data_ok`=0 throughout.
- Collision with lock: inst requests, bridge holds `addr_ok`=0 for 3 cycles, data raises `req` in cycle 1 → `mem_addr` stays the inst address until its `addr_ok`; data is granted the cycle after.
- Simultaneous requests, 4 rounds → with the macro, grants alternate I,D,I,D; without it, D every round until data drops `req`.
- Full FIFO (depth 4): 4 accepts with no `data_ok` → `mem_req`=0 while a 5th request is pending. One `data_ok` → `mem_req` reasserts the next cycle.
- Ordering: accept sequence D(load),I,D(store) with `data_ok` in 3 consecutive cycles → owners data, inst, data in that order; one push and one pop in the same cycle leaves the count unchanged.
- Withdrawal and reset: data `req` drops in LOCK_D before `addr_ok` → IDLE and no push. Pull `resetn` low with 2 outstanding → all outputs 0, and a later `mem_data_ok` sets `ret_err` with no `data_ok` pulse.

Source files
------------

// File: rtl/sram_req_arbiter.sv
// Two-to-one SRAM-like request arbiter with an in-order return-owner FIFO.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over inst.
module sram_req_arbiter #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = PW + 1;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

    typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

    state_t                     state, state_nxt;
    sram_req_t                  inst_fields, data_fields, sel_fields;
    logic                       idle_pick_data, sel_data, sel_req;
    logic                       fifo_full, fifo_empty, accept, pop, head_data;
    logic [MAX_OUTSTANDING-1:0] owner_q;
    logic [PW-1:0]              rd_ptr, wr_ptr;
    logic [CW-1:0]              count;
    logic                       ret_err;

    assign inst_fields = {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_addr, inst_sram_wdata};
    assign data_fields = {data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata};

`ifdef SRAM_ARB_RR_EN
    logic last_data;

    // On a tie the requester that did not win the previous accept goes first.
    assign idle_pick_data = data_sram_req & (~inst_sram_req | ~last_data);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     last_data <= 1'b1;
        else if (accept) last_data <= sel_data;
    end
`else
    assign idle_pick_data = data_sram_req;
`endif

    always_comb begin
        case (state)
            LOCK_I:  sel_data = 1'b0;
            LOCK_D:  sel_data = 1'b1;
            default: sel_data = idle_pick_data;
        endcase
    end

    assign sel_req    = sel_data ? data_sram_req : inst_sram_req;
    assign sel_fields = sel_data ? data_fields : inst_fields;
    assign fifo_full  = (count == CW'(MAX_OUTSTANDING));
    assign fifo_empty = (count == '0);

    // Every output is held at 0 while resetn is low, not just after the next edge.
    assign mem_req = resetn & sel_req & ~fifo_full;
    assign accept  = mem_req & mem_addr_ok;
    assign {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} = resetn ? sel_fields : '0;

    assign inst_sram_addr_ok = accept & ~sel_data;
    assign data_sram_addr_ok = accept & sel_data;

    assign pop               = resetn & mem_data_ok & ~fifo_empty;
    assign head_data         = owner_q[rd_ptr];
    assign inst_sram_data_ok = pop & ~head_data;
    assign data_sram_data_ok = pop & head_data;
    assign inst_sram_rdata   = mem_rdata;
    assign data_sram_rdata   = mem_rdata;

    always_comb begin
        state_nxt = state;
        if (!fifo_full) begin
            case (state)
                IDLE:    if (mem_req && !mem_addr_ok) state_nxt = sel_data ? LOCK_D : LOCK_I;
                LOCK_I,
                LOCK_D:  if (accept || !sel_req) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_q <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            ret_err <= 1'b0;
        end else begin
            if (accept) begin
                owner_q[wr_ptr] <= sel_data;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A response with nothing outstanding is a bridge protocol error.
            ret_err <= ret_err | (mem_data_ok & fifo_empty);
        end
    end
endmodule

// File: tb/tb_sram_req_arbiter.sv
// Self-checking bench for sram_req_arbiter: directed scenarios plus a randomized run
// against a queue-based model of owner ordering and grant policy.
module tb_sram_req_arbiter;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_req, inst_sram_wr, data_sram_req, data_sram_wr;
    logic [1:0]  inst_sram_size, data_sram_size, mem_size;
    logic [3:0]  inst_sram_wstrb, data_sram_wstrb, mem_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata, data_sram_addr, data_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] inst_sram_rdata, data_sram_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;

    // {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
    wire [4:0]  hs      = {mem_req, inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok};
    wire [70:0] mem_bus = {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata};

    always #5 clk = ~clk;

    sram_req_arbiter #(.MAX_OUTSTANDING(N)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
        .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    task automatic idle_in();
        inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wstrb = 4'h0;
        inst_sram_addr = 32'h0; inst_sram_wdata = 32'h0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_wstrb = 4'h0;
        data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
    endtask

    task automatic next();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle_in();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        inst_sram_req = 1; inst_sram_addr = 32'h1C000000; inst_sram_wdata = 32'hAAAA5555;
        inst_sram_wstrb = 4'hF; inst_sram_wr = 1;
        data_sram_req = 1; data_sram_addr = 32'h00002000; data_sram_wdata = 32'h12345678;
        data_sram_wstrb = 4'hF; data_sram_wr = 1;
        mem_addr_ok = 1; mem_data_ok = 1;
        @(negedge clk);
        checks++; if (hs !== 5'b0) begin errors++; $display("FAIL reset_handshake got=%b exp=00000", hs); end
        checks++; if (mem_bus !== '0) begin errors++; $display("FAIL reset_mem_fields got=%h exp=0", mem_bus); end
        checks++; if (dut.ret_err !== 1'b0) begin errors++; $display("FAIL reset_ret_err got=%b exp=0", dut.ret_err); end
        do_reset();
    endtask

    task automatic test_lone_fetch();
        do_reset();
        inst_sram_req = 1; inst_sram_addr = 32'h1C000000; mem_addr_ok = 1;
        @(negedge clk);
        checks++; if (hs !== 5'b11000) begin errors++; $display("FAIL lone_c0_hs got=%b exp=11000", hs); end
        checks++; if (mem_addr !== 32'h1C000000) begin errors++; $display("FAIL lone_c0_addr got=%h exp=1c000000", mem_addr); end
        next(); inst_sram_req = 0; mem_addr_ok = 0;
        @(negedge clk);
        checks++; if (hs !== 5'b00000) begin errors++; $display("FAIL lone_c1_hs got=%b exp=00000", hs); end
        next(); mem_data_ok = 1; mem_rdata = 32'h02800C0C;
        @(negedge clk);
        checks++; if (hs !== 5'b00010) begin errors++; $display("FAIL lone_c2_hs got=%b exp=00010", hs); end
        checks++; if (inst_sram_rdata !== 32'h02800C0C) begin errors++; $display("FAIL lone_rdata got=%h exp=02800c0c", inst_sram_rdata); end
        next(); idle_in();
    endtask

    task automatic test_lock();
        do_reset();
        inst_sram_req = 1; inst_sram_addr = 32'h1C000040;
        data_sram_addr = 32'h00001000;
        for (int c = 0; c < 3; c++) begin
            data_sram_req = (c >= 1);
            @(negedge clk);
            checks++; if (hs !== 5'b10000 || mem_addr !== 32'h1C000040) begin
                errors++; $display("FAIL lock_hold_c%0d hs=%b addr=%h exp hs=10000 addr=1c000040", c, hs, mem_addr); end
            next();
        end
        mem_addr_ok = 1;
        @(negedge clk);
        checks++; if (hs !== 5'b11000 || mem_addr !== 32'h1C000040) begin
            errors++; $display("FAIL lock_inst_accept hs=%b addr=%h exp hs=11000 addr=1c000040", hs, mem_addr); end
        next(); inst_sram_req = 0;
        @(negedge clk);
        checks++; if (hs !== 5'b10100 || mem_addr !== 32'h00001000) begin
            errors++; $display("FAIL lock_data_after hs=%b addr=%h exp hs=10100 addr=00001000", hs, mem_addr); end
        next(); data_sram_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        @(negedge clk);
        checks++; if (hs !== 5'b00010) begin errors++; $display("FAIL lock_ret_inst got=%b exp=00010", hs); end
        next();
        @(negedge clk);
        checks++; if (hs !== 5'b00001) begin errors++; $display("FAIL lock_ret_data got=%b exp=00001", hs); end
        next(); idle_in();
    endtask

    task automatic test_simultaneous();
        logic e, prev;
        do_reset();
        prev = 1'b0;
        for (int r = 0; r < 5; r++) begin
            inst_sram_req = 1; inst_sram_addr = 32'h1C000000 + 32'(r * 4);
            data_sram_req = (r < 4); data_sram_addr = 32'h00003000 + 32'(r * 4);
            mem_addr_ok = 1; mem_data_ok = (r > 0);
`ifdef SRAM_ARB_RR_EN
            e = (r % 2 == 1);
`else
            e = (r < 4);
`endif
            @(negedge clk);
            checks++; if (hs !== {1'b1, ~e, e, (r > 0) && !prev, (r > 0) && prev}) begin
                errors++; $display("FAIL simul_round%0d hs=%b exp=%b", r, hs, {1'b1, ~e, e, (r > 0) && !prev, (r > 0) && prev}); end
            checks++; if (mem_addr !== (e ? data_sram_addr : inst_sram_addr)) begin
                errors++; $display("FAIL simul_addr%0d got=%h exp=%h", r, mem_addr, e ? data_sram_addr : inst_sram_addr); end
            prev = e;
            next();
        end
        idle_in(); mem_data_ok = 1;
        @(negedge clk);
        checks++; if (hs !== 5'b00010) begin errors++; $display("FAIL simul_drain got=%b exp=00010", hs); end
        next(); idle_in();
    endtask

    task automatic test_full();
        do_reset();
        data_sram_req = 1; mem_addr_ok = 1;
        for (int i = 0; i < N; i++) begin
            data_sram_addr = 32'h00004000 + 32'(i * 4); data_sram_wr = i[0];
            @(negedge clk);
            checks++; if (hs !== 5'b10100) begin errors++; $display("FAIL full_fill%0d got=%b exp=10100", i, hs); end
            next();
        end
        @(negedge clk);
        checks++; if (hs !== 5'b00000) begin errors++; $display("FAIL full_block got=%b exp=00000", hs); end
        next(); mem_data_ok = 1;
        @(negedge clk);
        checks++; if (hs !== 5'b00001) begin errors++; $display("FAIL full_pop_same_cycle got=%b exp=00001", hs); end
        next(); mem_data_ok = 0;
        @(negedge clk);
        checks++; if (hs !== 5'b10100) begin errors++; $display("FAIL full_reassert got=%b exp=10100", hs); end
        next(); data_sram_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            checks++; if (hs !== 5'b00001) begin errors++; $display("FAIL full_drain%0d got=%b exp=00001", i, hs); end
            next();
        end
        idle_in();
    endtask

    task automatic test_order();
        do_reset();
        data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h00005000; mem_addr_ok = 1;
        @(negedge clk);
        checks++; if (hs !== 5'b10100) begin errors++; $display("FAIL order_c0 got=%b exp=10100", hs); end
        next(); data_sram_req = 0; inst_sram_req = 1; inst_sram_addr = 32'h1C000100; mem_data_ok = 1;
        @(negedge clk);
        checks++; if (hs !== 5'b11001) begin errors++; $display("FAIL order_c1 got=%b exp=11001", hs); end
        next(); inst_sram_req = 0; data_sram_req = 1; data_sram_wr = 1; data_sram_wstrb = 4'h3;
        @(negedge clk);
        checks++; if (hs !== 5'b10110 || mem_wr !== 1'b1 || mem_wstrb !== 4'h3) begin
            errors++; $display("FAIL order_c2 hs=%b wr=%b wstrb=%h exp hs=10110 wr=1 wstrb=3", hs, mem_wr, mem_wstrb); end
        next(); data_sram_req = 0; mem_addr_ok = 0;
        @(negedge clk);
        checks++; if (hs !== 5'b00001) begin errors++; $display("FAIL order_c3 got=%b exp=00001", hs); end
        next(); idle_in();
    endtask

    task automatic test_withdraw();
        do_reset();
        data_sram_req = 1; data_sram_addr = 32'h00006000;
        @(negedge clk);
        checks++; if (hs !== 5'b10000) begin errors++; $display("FAIL wd_lock got=%b exp=10000", hs); end
        next(); data_sram_req = 0; inst_sram_req = 1; inst_sram_addr = 32'h1C000200; mem_addr_ok = 1;
        @(negedge clk);
        checks++; if (hs !== 5'b00000) begin errors++; $display("FAIL wd_drop got=%b exp=00000", hs); end
        next();
        @(negedge clk);
        checks++; if (hs !== 5'b11000) begin errors++; $display("FAIL wd_inst_grant got=%b exp=11000", hs); end
        next(); inst_sram_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        @(negedge clk);
        checks++; if (hs !== 5'b00010) begin errors++; $display("FAIL wd_no_push got=%b exp=00010", hs); end
        next(); idle_in();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        inst_sram_req = 1; mem_addr_ok = 1;
        next(); inst_sram_req = 0; data_sram_req = 1;
        next();
        resetn = 0; inst_sram_req = 1; inst_sram_addr = 32'hDEADBEEF; mem_data_ok = 1;
        @(negedge clk);
        checks++; if (hs !== 5'b00000 || mem_bus !== '0) begin
            errors++; $display("FAIL rst_mid_outputs hs=%b bus=%h exp all 0", hs, mem_bus); end
        next(); idle_in(); resetn = 1; mem_data_ok = 1;
        @(negedge clk);
        checks++; if (hs !== 5'b00000) begin errors++; $display("FAIL rst_stale_data_ok got=%b exp=00000", hs); end
        next(); idle_in();
        @(negedge clk);
        checks++; if (dut.ret_err !== 1'b1) begin errors++; $display("FAIL rst_ret_err got=%b exp=1", dut.ret_err); end
        next();
    endtask

    task automatic test_random();
        int q[$];
        int hold, last, sel;
        logic full, exp_req, exp_acc, ido, ddo;
        do_reset();
        hold = -1; last = 1;
        for (int c = 0; c < 600; c++) begin
            inst_sram_req = ($urandom_range(0, 3) != 0);
            data_sram_req = ($urandom_range(0, 3) != 0);
            inst_sram_addr = $urandom; data_sram_addr = $urandom;
            inst_sram_wr = 1'($urandom); data_sram_wr = 1'($urandom);
            mem_addr_ok = ($urandom_range(0, 2) == 0);
            mem_data_ok = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            mem_rdata = $urandom;
            full = (q.size() == N);
            sel = -1;
            if (hold >= 0) sel = hold;
            else if (inst_sram_req && data_sram_req) begin
`ifdef SRAM_ARB_RR_EN
                sel = (last == 1) ? 0 : 1;
`else
                sel = 1;
`endif
            end
            else if (data_sram_req) sel = 1;
            else if (inst_sram_req) sel = 0;
            exp_req = !full && sel >= 0 && ((sel == 1) ? data_sram_req : inst_sram_req);
            exp_acc = exp_req && mem_addr_ok;
            ido = mem_data_ok && q.size() > 0 && q[0] == 0;
            ddo = mem_data_ok && q.size() > 0 && q[0] == 1;
            @(negedge clk);
            checks++; if (hs !== {exp_req, exp_acc && sel == 0, exp_acc && sel == 1, ido, ddo}) begin
                errors++; $display("FAIL rand_hs cyc=%0d got=%b exp=%b", c, hs, {exp_req, exp_acc && sel == 0, exp_acc && sel == 1, ido, ddo}); end
            if (exp_req) begin
                checks++; if (mem_addr !== ((sel == 1) ? data_sram_addr : inst_sram_addr)) begin
                    errors++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", c, mem_addr, (sel == 1) ? data_sram_addr : inst_sram_addr); end
            end
            if (mem_data_ok && q.size() > 0) void'(q.pop_front());
            if (exp_acc) begin
                q.push_back(sel); last = sel; hold = -1;
            end else if (!full) begin
                if (hold >= 0 && !exp_req) hold = -1;
                else if (hold < 0 && exp_req) hold = sel;
            end
            next();
        end
        idle_in();
    endtask

    initial begin
        resetn = 1'b0;
        idle_in();
        test_reset();
        test_lone_fetch();
        test_lock();
        test_simultaneous();
        test_full();
        test_order();
        test_withdraw();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
